// File: rtl/approx_mul_pkg.sv
`default_nettype none
// ============================================================================
// Module   : approx_mul_pkg
// Purpose  : Shared types and helpers for the sequential approximate
//            multiplier family (approx_mul_seq, approx_mul_pp_mask).
// Contents : state_t      - controller state encoding (IDLE, BUSY, DONE)
//            kw_of()      - width of a truncation level able to hold 0..2W
//            jw_of()      - width of a step counter that indexes 0..W-1
//            comp_const() - bias-compensation constant 2^(k-1), 0 < k < 2W
// Revision : 1.0 - initial release
// ============================================================================
package approx_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width needed to represent any truncation level 0..2W.
  function automatic int kw_of(input int w);
    return $clog2(2 * w + 1);
  endfunction

  // Width of the multiplier-bit step counter; never less than one bit.
  function automatic int jw_of(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  // Half of the weight of the lowest kept column. Adding it centres the
  // truncation error around zero. Zero when nothing (k=0) or everything
  // (k>=2W) is dropped, since there is no error to centre in those cases.
  function automatic logic [63:0] comp_const(input int k, input int w);
    if (k > 0 && k < 2 * w) begin
      return 64'd1 << (k - 1);
    end
    return 64'd0;
  endfunction

endpackage : approx_mul_pkg
`default_nettype wire

// File: rtl/approx_mul_pp_mask.sv
`default_nettype none
// ============================================================================
// Module   : approx_mul_pp_mask
// Purpose  : Combinational partial-product column mask. For the partial
//            product of multiplier bit j, multiplicand bit i lands in column
//            i+j; the bit is kept only when that column is >= k.
// Ports    : j    in  JW  multiplier bit index of the current partial product
//            k    in  KW  number of low product columns dropped (0..2W)
//            mask out W   bit i set when multiplicand bit i is kept
// Revision : 1.0 - initial release
// ============================================================================
module approx_mul_pp_mask
  import approx_mul_pkg::*;
#(
  parameter int W  = 8,
  parameter int KW = kw_of(W),
  parameter int JW = jw_of(W)
) (
  input  logic [JW-1:0] j,
  input  logic [KW-1:0] k,
  output logic [W-1:0]  mask
);

  // Compare in 32-bit unsigned so i+j cannot wrap for any legal W.
  for (genvar i = 0; i < W; i++) begin : g_col
    assign mask[i] = ((32'(i) + 32'(j)) >= 32'(k));
  end

endmodule : approx_mul_pp_mask
`default_nettype wire

// File: rtl/approx_mul_seq.sv
`default_nettype none
// ============================================================================
// Module   : approx_mul_seq
// Purpose  : Sequential W x W unsigned multiplier, one multiplier bit per
//            cycle, with a per-operation approximation level. Partial-product
//            columns below trunc_k are dropped before accumulation.
// Ports    : clk       in  1   clock, rising edge
//            rst_n     in  1   asynchronous active-low reset
//            in_valid  in  1   a, b, trunc_k valid
//            in_ready  out 1   block can accept an operation
//            a         in  W   multiplicand, unsigned
//            b         in  W   multiplier, unsigned
//            trunc_k   in  KW  low product columns to drop (0 = exact,
//                              values above 2W saturate to 2W)
//            out_valid out 1   product valid
//            out_ready in  1   consumer accepts product
//            p         out 2W  approximate product
//            busy      out 1   operation in progress
// Options  : APPROX_MUL_ERRCOMP_EN - add 2^(k-1) bias compensation to the
//            result (saturating), registered with the result so latency
//            is unchanged.
// Timing   : accept edge is cycle 0; out_valid rises W cycles later and
//            holds with p until out_ready; in_ready returns on the
//            handshake edge.
// Revision : 1.0 - initial release
// ============================================================================
module approx_mul_seq
  import approx_mul_pkg::*;
#(
  parameter int W  = 8,
  parameter int KW = $clog2(2 * W + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  input  logic [KW-1:0] trunc_k,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [2*W-1:0] p,
  output logic          busy
);

  localparam int              JW     = jw_of(W);
  localparam int              PW     = 2 * W;
  localparam logic [KW-1:0]   K_MAX  = KW'(PW);
  localparam logic [JW-1:0]   J_LAST = JW'(W - 1);

  state_t          state;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [KW-1:0]   k_q;
  logic [JW-1:0]   j;
  logic [PW-1:0]   acc;

  logic [KW-1:0]   k_sat;
  logic [W-1:0]    mask;
  logic [PW-1:0]   addend;
  logic [PW-1:0]   acc_next;
  logic [PW-1:0]   result;

  // Saturate the truncation level at accept; 2W already drops every column.
  assign k_sat = (trunc_k > K_MAX) ? K_MAX : trunc_k;

  approx_mul_pp_mask #(
    .W  (W),
    .KW (KW),
    .JW (JW)
  ) u_pp_mask (
    .j    (j),
    .k    (k_q),
    .mask (mask)
  );

  // Masked partial product for multiplier bit j, placed at column j.
  always_comb begin
    addend = '0;
    if (b_q[j]) begin
      addend = PW'(a_q & mask) << j;
    end
  end

  // Cannot overflow: the full sum is bounded by (2^W-1)^2 < 2^(2W).
  assign acc_next = acc + addend;

`ifdef APPROX_MUL_ERRCOMP_EN
  logic [63:0] comp_full;
  logic [PW:0] comp_sum;

  assign comp_full = comp_const(int'(k_q), W);
  assign comp_sum  = {1'b0, acc_next} + {1'b0, comp_full[PW-1:0]};
  assign result    = comp_sum[PW] ? {PW{1'b1}} : comp_sum[PW-1:0];
`else
  assign result = acc_next;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      p         <= '0;
      busy      <= 1'b0;
      acc       <= '0;
      j         <= '0;
      a_q       <= '0;
      b_q       <= '0;
      k_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            k_q      <= k_sat;
            acc      <= '0;
            j        <= '0;
            state    <= BUSY;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end

        BUSY: begin
          acc <= acc_next;
          if (j == J_LAST) begin
            // Final step: the result (with the last partial product and
            // any compensation) is captured directly into p.
            p         <= result;
            out_valid <= 1'b1;
            j         <= '0;
            state     <= DONE;
          end else begin
            j <= j + 1'b1;
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule : approx_mul_seq
`default_nettype wire

// File: tb/tb_approx_mul_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_approx_mul_seq
// Purpose  : Self-checking bench for approx_mul_seq at W=8 and W=12.
//            Directed cases plus randomized operations compared against a
//            column-sum reference model of the truncated product.
// Revision : 1.0 - initial release
// ============================================================================
module tb_approx_mul_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // W = 8 instance
  logic        iv8, ir8, ov8, or8, busy8;
  logic [7:0]  a8, b8;
  logic [4:0]  k8;
  logic [15:0] p8;

  // W = 12 instance
  logic        iv12, ir12, ov12, or12, busy12;
  logic [11:0] a12, b12;
  logic [4:0]  k12;
  logic [23:0] p12;

  int pass_cnt  = 0;
  int total_cnt = 0;

  approx_mul_seq #(.W(8)) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv8),
    .in_ready  (ir8),
    .a         (a8),
    .b         (b8),
    .trunc_k   (k8),
    .out_valid (ov8),
    .out_ready (or8),
    .p         (p8),
    .busy      (busy8)
  );

  approx_mul_seq #(.W(12)) u_dut12 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv12),
    .in_ready  (ir12),
    .a         (a12),
    .b         (b12),
    .trunc_k   (k12),
    .out_valid (ov12),
    .out_ready (or12),
    .p         (p12),
    .busy      (busy12)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: sum of a_i*b_j*2^(i+j) over kept columns i+j >= min(k,2W).
  function automatic longint unsigned ref_p(input longint unsigned av,
                                            input longint unsigned bv,
                                            input int k, input int w);
    longint unsigned s;
    longint unsigned maxv;
    int ke;
    s    = 0;
    ke   = (k > 2 * w) ? 2 * w : k;
    maxv = (64'd1 << (2 * w)) - 1;
    for (int i = 0; i < w; i++) begin
      for (int jj = 0; jj < w; jj++) begin
        if (av[i] && bv[jj] && (i + jj >= ke)) begin
          s += 64'd1 << (i + jj);
        end
      end
    end
`ifdef APPROX_MUL_ERRCOMP_EN
    if (ke > 0 && ke < 2 * w) begin
      s += 64'd1 << (ke - 1);
      if (s > maxv) s = maxv;
    end
`endif
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One W=8 operation. Holds out_ready low for 'stall' cycles after
  // out_valid rises, then completes the handshake.
  task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic [4:0] kv,
                     input int stall, input string tag, output logic [15:0] p_got);
    int lat, irlow, wc;
    logic [15:0] exp, held;
    exp = 16'(ref_p(64'(av), 64'(bv), int'(kv), 8));
    wc = 0;
    while (!ir8 && wc < 50) begin
      tick();
      wc++;
    end
    check({tag, " ready"}, 64'(ir8), 64'd1);
    iv8 = 1'b1; a8 = av; b8 = bv; k8 = kv;
    or8 = (stall == 0);
    tick();
    // Inputs change after accept; trunc_k must not be re-sampled.
    iv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); k8 = 5'($urandom);
    lat = 0; irlow = 0;
    while (!ov8 && lat < 40) begin
      if (!ir8) irlow++;
      tick();
      lat++;
    end
    if (!ir8) irlow++;
    check({tag, " latency"}, 64'(lat), 64'd8);
    check({tag, " p"}, 64'(p8), 64'(exp));
    held  = p8;
    p_got = p8;
    for (int s = 0; s < stall; s++) begin
      tick();
      if (!ir8) irlow++;
      check({tag, " hold"}, {ov8, ir8, p8}, {1'b1, 1'b0, held});
    end
    or8 = 1'b1;
    tick();
    check({tag, " in_ready low cycles"}, 64'(irlow), 64'(9 + stall));
    check({tag, " release"}, {ov8, ir8, busy8}, 3'b010);
  endtask

  task automatic op12(input logic [11:0] av, input logic [11:0] bv, input logic [4:0] kv,
                      input string tag);
    int lat, wc;
    logic [23:0] exp;
    exp = 24'(ref_p(64'(av), 64'(bv), int'(kv), 12));
    wc = 0;
    while (!ir12 && wc < 50) begin
      tick();
      wc++;
    end
    check({tag, " ready"}, 64'(ir12), 64'd1);
    iv12 = 1'b1; a12 = av; b12 = bv; k12 = kv; or12 = 1'b1;
    tick();
    iv12 = 1'b0; k12 = 5'($urandom);
    lat = 0;
    while (!ov12 && lat < 40) begin
      tick();
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'd12);
    check({tag, " p"}, 64'(p12), 64'(exp));
    tick();
    check({tag, " release"}, {ov12, ir12}, 2'b01);
  endtask

  initial begin : main
    logic [15:0] pg;
    logic [4:0]  kr;
    int wc;

    rst_n = 1'b0;
    iv8 = 0; or8 = 0; a8 = 0; b8 = 0; k8 = 0;
    iv12 = 0; or12 = 0; a12 = 0; b12 = 0; k12 = 0;
    tick();
    tick();
    check("reset w8", {ir8, ov8, busy8, p8}, {1'b1, 1'b0, 1'b0, 16'd0});
    check("reset w12", {ir12, ov12, busy12, p12}, {1'b1, 1'b0, 1'b0, 24'd0});
    rst_n = 1'b1;
    tick();

    // Directed cases with fixed expected values.
    op8(8'd255, 8'd255, 5'd0, 0, "exact_max", pg);
    check("exact_max const", 64'(pg), 64'd65025);
    op8(8'd15, 8'd15, 5'd4, 0, "trunc4", pg);
`ifdef APPROX_MUL_ERRCOMP_EN
    check("trunc4 const", 64'(pg), 64'd184);
`else
    check("trunc4 const", 64'(pg), 64'd176);
`endif
    op8(8'd200, 8'd99, 5'd20, 0, "ksat", pg);
    check("ksat const", 64'(pg), 64'd0);
    op8(8'd0, 8'd0, 5'd0, 0, "zero", pg);
    check("zero const", 64'(pg), 64'd0);

    // Backpressure with a second request pending while out_valid is held.
    iv8 = 1'b1; a8 = 8'd3; b8 = 8'd5; k8 = 5'd0; or8 = 1'b0;
    tick();
    iv8 = 1'b0;
    wc = 0;
    while (!ov8 && wc < 40) begin
      tick();
      wc++;
    end
    check("bp latency", 64'(wc), 64'd8);
    check("bp p", 64'(p8), 64'd15);
    iv8 = 1'b1; a8 = 8'd9; b8 = 8'd11; k8 = 5'd0;
    for (int s = 0; s < 3; s++) begin
      tick();
      check("bp hold", {ov8, ir8, busy8, p8}, {1'b1, 1'b0, 1'b1, 16'd15});
    end
    or8 = 1'b1;
    tick();
    check("bp handshake no accept", {ov8, ir8, busy8}, 3'b010);
    tick();
    check("bp accept next", {ir8, busy8}, 2'b01);
    iv8 = 1'b0;
    wc = 0;
    while (!ov8 && wc < 40) begin
      tick();
      wc++;
    end
    check("bp second p", 64'(p8), 64'd99);
    tick();

    // Reset during an operation.
    iv8 = 1'b1; a8 = 8'd100; b8 = 8'd100; k8 = 5'd0; or8 = 1'b1;
    tick();
    iv8 = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    check("async reset", {ir8, ov8, busy8, p8}, {1'b1, 1'b0, 1'b0, 16'd0});
    tick();
    check("reset held no output", {ov8, busy8}, 2'b00);
    rst_n = 1'b1;
    tick();
    op8(8'd7, 8'd9, 5'd0, 0, "post_reset", pg);
    check("post_reset const", 64'(pg), 64'd63);

    // Random sweep W=8: mixed backpressure and back-to-back operations.
    for (int n = 0; n < 1500; n++) begin
      kr = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(17, 31))
                                       : 5'($urandom_range(0, 16));
      op8(8'($urandom), 8'($urandom), kr,
          ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3)),
          "rand8", pg);
    end

    // Random sweep W=12, back-to-back with out_ready high.
    for (int n = 0; n < 600; n++) begin
      kr = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(25, 31))
                                       : 5'($urandom_range(0, 24));
      op12(12'($urandom), 12'($urandom), kr, "rand12");
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_approx_mul_seq
`default_nettype wire
